// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: arbiter state encodings and the default watchdog limit
package bus_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANTED, ARB_TURNAROUND} arb_state_t;
    localparam int DEFAULT_TIMEOUT = 1024;
endpackage

// File: rtl/bus_rr_picker.sv
// bus_rr_picker: round-robin priority encoder, scans last+1, last+2, ... modulo N
module bus_rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] win,
    output logic         any
);
    always_comb begin
        win = '0;
        any = |req;
        // descending scan so the nearest requester after last overwrites the others
        for (int k = N; k >= 1; k--)
            if (req[(int'(last) + k) % N]) win = W'((int'(last) + k) % N);
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with one-cycle turnaround and strobe watchdog
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MASTERS = 4,
    parameter int OWNER_W = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MASTERS-1:0] bus_req,
    output logic [MASTERS-1:0] bus_grant,
    input  logic               rd_bus,
    input  logic               wr_bus,
    input  logic               fc_bus,
    output logic [OWNER_W-1:0] owner,
    output logic               owner_valid,
    output logic               bus_timeout,
    output logic [OWNER_W-1:0] err_master
);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    arb_state_t         state_q;
    logic [MASTERS-1:0] grant_q;
    logic [OWNER_W-1:0] owner_q, last_q, err_q, win;
    logic               valid_q, timeout_q, any;
    logic [TO_W-1:0]    wd_q;

    bus_rr_picker #(.N(MASTERS), .W(OWNER_W)) u_picker (
        .req  (bus_req),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            valid_q   <= 1'b0;
            last_q    <= OWNER_W'(MASTERS - 1);
            timeout_q <= 1'b0;
            err_q     <= '0;
            wd_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ARB_IDLE, ARB_TURNAROUND: begin
                    wd_q    <= '0;
                    state_q <= any ? ARB_GRANTED : ARB_IDLE;
                    if (any) begin
                        grant_q <= MASTERS'(1) << win;
                        owner_q <= win;
                        last_q  <= win;
                        valid_q <= 1'b1;
                    end
                end
                ARB_GRANTED: begin
                    if (!bus_req[owner_q]) begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        wd_q    <= '0;
                        state_q <= ARB_TURNAROUND;
                    end else if (fc_bus || !(rd_bus || wr_bus)) begin
                        wd_q <= '0;
                    end else if (TIMEOUT != 0 && wd_q != TO_MAX) begin
                        // counter saturates at the limit so a stuck stall pulses only once
                        wd_q <= wd_q + 1'b1;
                        if (wd_q == TO_MAX - 1'b1) begin
                            timeout_q <= 1'b1;
                            err_q     <= owner_q;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus_grant   = grant_q;
    assign owner       = owner_q;
    assign owner_valid = valid_q;
    assign bus_timeout = timeout_q;
    assign err_master  = err_q;
endmodule
